// File: rtl/gnr_attractor_ctrl_if.sv
// Node-network and result-handshake bundle for gnr_attractor_ctrl.
// master = controller side, slave = node network / result consumer side.
interface gnr_attractor_ctrl_if #(
    parameter int unsigned N_NODES = 8,
    parameter int unsigned CNT_W   = 16
);
    logic               reset_nos;
    logic [N_NODES-1:0] init_state;
    logic               start_s0;
    logic               start_s1;
    logic [N_NODES-1:0] s0_vec;
    logic [N_NODES-1:0] s1_vec;

    logic               res_valid;
    logic               res_ready;
    logic [N_NODES-1:0] res_init;
    logic [CNT_W-1:0]   res_transient;
    logic [CNT_W-1:0]   res_period;
    logic               res_timeout;

    modport master (
        output reset_nos, init_state, start_s0, start_s1,
        output res_valid, res_init, res_transient, res_period, res_timeout,
        input  s0_vec, s1_vec, res_ready
    );

    modport slave (
        input  reset_nos, init_state, start_s0, start_s1,
        input  res_valid, res_init, res_transient, res_period, res_timeout,
        output s0_vec, s1_vec, res_ready
    );
endinterface

// File: rtl/gnr_attractor_ctrl.sv
// Sweeps a range of initial states through a node network, using Floyd's slow/fast copies
// to find the meet index and attractor period of each, and reports one result per state.
module gnr_attractor_ctrl #(
    parameter int unsigned N_NODES = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_NODES-1:0]   cfg_first,
    input  logic [N_NODES-1:0]   cfg_last,
    output logic                 busy,
    output logic                 done,
    gnr_attractor_ctrl_if.master bus
);
    localparam logic [CNT_W-1:0] MaxSteps = '1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StPeriod,
        StReport,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [N_NODES-1:0] cur_q, cur_d;
    logic [N_NODES-1:0] last_q, last_d;
    logic [CNT_W-1:0]   e_q, e_d;
    logic [CNT_W-1:0]   p_q, p_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic               to_q, to_d;

    logic               load_en;
    logic               run_s0;
    logic               run_s1;
    logic               vec_eq;

    assign vec_eq = (bus.s0_vec == bus.s1_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cur_q   <= '0;
            last_q  <= '0;
            e_q     <= '0;
            p_q     <= '0;
            k_q     <= '0;
            per_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            e_q     <= e_d;
            p_q     <= p_d;
            k_q     <= k_d;
            per_q   <= per_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        e_d     = e_q;
        p_d     = p_q;
        k_d     = k_q;
        per_d   = per_q;
        to_d    = to_q;
        load_en = 1'b0;
        run_s0  = 1'b0;
        run_s1  = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    cur_d   = cfg_first;
                    // An inverted range collapses to the single state cfg_first.
                    last_d  = (cfg_last < cfg_first) ? cfg_first : cfg_last;
                    state_d = StLoad;
                end
            end

            StLoad: begin
                load_en = 1'b1;
                e_d     = '0;
                p_d     = '0;
                k_d     = '0;
                per_d   = '0;
                to_d    = 1'b0;
                state_d = StRun;
            end

            StRun: begin
                if ((e_q != '0) && !e_q[0] && vec_eq) begin
                    k_d     = e_q >> 1;
                    state_d = StPeriod;
                end else if (e_q == MaxSteps) begin
                    to_d    = 1'b1;
                    state_d = StReport;
                end else begin
                    run_s0 = 1'b1;
                    run_s1 = 1'b1;
                    e_d    = e_q + CNT_W'(1);
                end
            end

            StPeriod: begin
                // Slow copy sits on the attractor; walk the fast copy round it once.
                if ((p_q != '0) && vec_eq) begin
                    per_d   = p_q;
                    state_d = StReport;
                end else if (p_q == MaxSteps) begin
                    to_d    = 1'b1;
                    state_d = StReport;
                end else begin
                    run_s1 = 1'b1;
                    p_d    = p_q + CNT_W'(1);
                end
            end

            StReport: begin
                if (bus.res_ready) begin
                    if (cur_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        cur_d   = cur_q + N_NODES'(1);
                        state_d = StLoad;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q == StLoad) || (state_q == StRun) ||
                  (state_q == StPeriod) || (state_q == StReport);
    assign done = (state_q == StDone);

    assign bus.reset_nos     = load_en;
    assign bus.init_state    = load_en ? cur_q : '0;
    assign bus.start_s0      = run_s0;
    assign bus.start_s1      = run_s1;

    // On timeout the fields not yet measured stay at zero.
    assign bus.res_valid     = (state_q == StReport);
    assign bus.res_init      = cur_q;
    assign bus.res_transient = k_q;
    assign bus.res_period    = per_q;
    assign bus.res_timeout   = to_q;

    property p_report_hold;
        @(posedge clk) disable iff (rst)
        bus.res_valid && !bus.res_ready |=> bus.res_valid && $stable(bus.res_init) &&
            $stable(bus.res_transient) && $stable(bus.res_period) && $stable(bus.res_timeout);
    endproperty
    a_report_hold : assert property (p_report_hold);

    a_quiet_when_idle : assert property (@(posedge clk) disable iff (rst)
        !busy || bus.res_valid |-> !(bus.reset_nos || bus.start_s0 || bus.start_s1));
endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Randomised sweeps of two controllers (wide and narrow counters) over a modelled node network,
// checked every cycle against a direct Floyd-search reference.
module tb_gnr_attractor_ctrl;
    localparam int unsigned NN        = 3;
    localparam int unsigned CW_WIDE   = 16;
    localparam int unsigned CW_NARROW = 3;
    localparam int          NI        = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NN-1:0] cfg_first;
    logic [NN-1:0] cfg_last;
    logic          res_ready;
    logic [NI-1:0] busy_v;
    logic [NI-1:0] done_v;

    gnr_attractor_ctrl_if #(.N_NODES(NN), .CNT_W(CW_WIDE))   bus0 ();
    gnr_attractor_ctrl_if #(.N_NODES(NN), .CNT_W(CW_NARROW)) bus1 ();

    gnr_attractor_ctrl #(.N_NODES(NN), .CNT_W(CW_WIDE)) dut0 (
        .clk(clk), .rst(rst), .start(start), .cfg_first(cfg_first), .cfg_last(cfg_last),
        .busy(busy_v[0]), .done(done_v[0]), .bus(bus0)
    );
    gnr_attractor_ctrl #(.N_NODES(NN), .CNT_W(CW_NARROW)) dut1 (
        .clk(clk), .rst(rst), .start(start), .cfg_first(cfg_first), .cfg_last(cfg_last),
        .busy(busy_v[1]), .done(done_v[1]), .bus(bus1)
    );

    always #5 clk = ~clk;

    // Network transfer function: 0 identity, 1 increment, else lookup table.
    int            mode = 0;
    logic [NN-1:0] lut [8];

    function automatic logic [NN-1:0] f(input logic [NN-1:0] x);
        case (mode)
            0:       return x;
            1:       return x + NN'(1);
            default: return lut[x];
        endcase
    endfunction

    logic [NN-1:0] n0_s0, n0_s1, n1_s0, n1_s1;
    logic          n0_ph, n1_ph;

    always @(posedge clk) begin
        if (bus0.reset_nos) begin
            n0_s0 <= bus0.init_state; n0_s1 <= bus0.init_state; n0_ph <= 1'b0;
        end else begin
            if (bus0.start_s0) begin
                if (!n0_ph) n0_s0 <= f(n0_s0);
                n0_ph <= ~n0_ph;
            end
            if (bus0.start_s1) n0_s1 <= f(n0_s1);
        end
    end

    always @(posedge clk) begin
        if (bus1.reset_nos) begin
            n1_s0 <= bus1.init_state; n1_s1 <= bus1.init_state; n1_ph <= 1'b0;
        end else begin
            if (bus1.start_s0) begin
                if (!n1_ph) n1_s0 <= f(n1_s0);
                n1_ph <= ~n1_ph;
            end
            if (bus1.start_s1) n1_s1 <= f(n1_s1);
        end
    end

    assign bus0.s0_vec = n0_s0;
    assign bus0.s1_vec = n0_s1;
    assign bus1.s0_vec = n1_s0;
    assign bus1.s1_vec = n1_s1;
    assign bus0.res_ready = res_ready;
    assign bus1.res_ready = res_ready;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Reference: iterate f directly to find the meet index and the cycle length.
    function automatic void ref_result(input int x, input int maxv,
                                       output int tr, output int per, output bit to);
        logic [NN-1:0] slow, fast;
        int k, p;
        slow = NN'(x);
        fast = NN'(x);
        k = 0;
        tr = 0; per = 0; to = 1'b0;
        do begin
            slow = f(slow);
            fast = f(f(fast));
            k++;
        end while (slow != fast);
        if (2 * k > maxv) begin
            to = 1'b1;
            return;
        end
        tr = k;
        p = 1;
        fast = f(slow);
        while (fast != slow) begin
            fast = f(fast);
            p++;
        end
        if (p > maxv) to = 1'b1;
        else per = p;
    endfunction

    typedef struct packed {
        logic          busy, done, reset_nos, start_s0, start_s1, res_valid, res_timeout;
        logic [NN-1:0] init_state, res_init;
        logic [15:0]   res_transient, res_period;
    } snap_t;

    function automatic snap_t snap(input int i);
        snap_t s;
        if (i == 0) begin
            s = '{busy_v[0], done_v[0], bus0.reset_nos, bus0.start_s0, bus0.start_s1,
                  bus0.res_valid, bus0.res_timeout, bus0.init_state, bus0.res_init,
                  16'(bus0.res_transient), 16'(bus0.res_period)};
        end else begin
            s = '{busy_v[1], done_v[1], bus1.reset_nos, bus1.start_s0, bus1.start_s1,
                  bus1.res_valid, bus1.res_timeout, bus1.init_state, bus1.res_init,
                  16'(bus1.res_transient), 16'(bus1.res_period)};
        end
        return s;
    endfunction

    int maxv_m [NI] = '{65535, 7};
    int cur_m  [NI];
    int last_m [NI];
    bit act_m  [NI];
    bit done_m [NI];
    bit rst_prev = 1'b0;

    always @(negedge clk) begin : cmp
        snap_t s;
        int    tr, per;
        bit    to;
        for (int i = 0; i < NI; i++) begin
            s = snap(i);
            if (rst_prev) begin
                check($sformatf("reset_zero[%0d]", i), int'(s != '0), 0);
            end else begin
                check($sformatf("busy[%0d]", i), int'(s.busy), int'(act_m[i]));
                check($sformatf("done[%0d]", i), int'(s.done), int'(done_m[i]));
                if (!act_m[i] || s.res_valid)
                    check($sformatf("quiet[%0d]", i),
                          int'({s.reset_nos, s.start_s0, s.start_s1}), 0);
                if (!act_m[i]) check($sformatf("no_valid[%0d]", i), int'(s.res_valid), 0);
                if (s.res_valid && act_m[i]) begin
                    ref_result(cur_m[i], maxv_m[i], tr, per, to);
                    check($sformatf("res_init[%0d]", i), int'(s.res_init), cur_m[i]);
                    check($sformatf("res_transient[%0d]", i), int'(s.res_transient), tr);
                    check($sformatf("res_period[%0d]", i), int'(s.res_period), per);
                    check($sformatf("res_timeout[%0d]", i), int'(s.res_timeout), int'(to));
                end
            end
            // Advance the model across the coming edge.
            if (rst) begin
                act_m[i]  = 1'b0;
                done_m[i] = 1'b0;
            end else if (!act_m[i] && start) begin
                cur_m[i]  = int'(cfg_first);
                last_m[i] = (cfg_last < cfg_first) ? int'(cfg_first) : int'(cfg_last);
                act_m[i]  = 1'b1;
                done_m[i] = 1'b0;
            end else if (act_m[i] && s.res_valid && res_ready) begin
                if (cur_m[i] == last_m[i]) begin
                    act_m[i]  = 1'b0;
                    done_m[i] = 1'b1;
                end else begin
                    cur_m[i]++;
                end
            end
        end
        rst_prev = rst;
    end

    int hold = 0;
    bit force_hold = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (force_hold && bus0.res_valid) begin
            hold = 5;
            force_hold = 1'b0;
        end
        if (hold > 0) begin
            res_ready = 1'b0;
            hold--;
        end else begin
            res_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) hold = 5;
        end
    endtask

    task automatic launch(input int md, input int first, input int last);
        mode = md;
        if (md == 2) for (int j = 0; j < 8; j++) lut[j] = NN'($urandom_range(0, 7));
        cfg_first = NN'(first);
        cfg_last  = NN'(last);
        start = 1'b1;
        tick();
        start = 1'b0;
        // Scramble cfg to show it was captured at the accepted start.
        cfg_first = NN'($urandom_range(0, 7));
        cfg_last  = NN'($urandom_range(0, 7));
    endtask

    task automatic sweep(input int md, input int first, input int last, input bit poke);
        int n;
        launch(md, first, last);
        n = 0;
        while (done_v != 2'b11 && n < 6000) begin
            if (poke && busy_v == 2'b11 && $urandom_range(0, 15) == 0) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
        if (n >= 6000) check("sweep_budget", n, 0);
    endtask

    initial begin
        int tr, per;
        bit to;
        rst = 1'b1; start = 1'b0; cfg_first = '0; cfg_last = '0; res_ready = 1'b0;
        for (int j = 0; j < 8; j++) lut[j] = NN'(j);

        // Pin the reference against hand-worked cases.
        mode = 0;
        ref_result(5, 65535, tr, per, to);
        check("pin_identity", tr * 100 + per * 10 + int'(to), 110);
        mode = 1;
        ref_result(0, 65535, tr, per, to);
        check("pin_increment", tr * 100 + per * 10 + int'(to), 880);
        ref_result(3, 7, tr, per, to);
        check("pin_inc_narrow", tr * 100 + per * 10 + int'(to), 1);
        mode = 0;

        repeat (3) tick();
        rst = 1'b0;
        tick();

        force_hold = 1'b1;
        sweep(0, 5, 5, 1'b0);
        sweep(1, 0, 7, 1'b0);

        // Abort mid-RUN, then restart from cfg_first.
        launch(1, 0, 7);
        repeat (12) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        sweep(1, 0, 7, 1'b0);

        sweep(1, 6, 2, 1'b1);
        for (int r = 0; r < 10; r++)
            sweep(int'($urandom_range(0, 2)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), 1'b1);

        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d",
                 passed, total);
        $fatal(1);
    end
endmodule
